// File: rtl/ser_xmt_frame.sv
// ============================================================================
// ser_xmt_frame
// ----------------------------------------------------------------------------
// Asynchronous serial transmitter framing stage. Takes one byte per
// load/empty handshake and shifts it out on serial_out as:
//   start (0), d0..d7 (LSB first), optional parity, 1 or 2 stop bits (1).
// Each bit is held for BAUD_DIV clock cycles.
//
// Parameters:
//   BAUD_DIV  - clock cycles per serial bit (2..65535)
//   PARITY    - 0 none, 1 even, 2 odd, 3 none
//   STOP_BITS - 1 or 2 (anything else behaves as 1)
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   load       - latch data_in and start a frame (honoured only while empty=1)
//   empty      - 1 = idle and ready, 0 = frame in progress (registered)
//   data_in    - byte to transmit, sampled on an accepted load
//   serial_out - serial line, idle high (registered)
// ============================================================================
module ser_xmt_frame #(
    parameter int BAUD_DIV  = 434,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    output logic       empty,
    input  logic [7:0] data_in,
    output logic       serial_out
);

    localparam int          PAR_EN    = ((PARITY == 1) || (PARITY == 2)) ? 1 : 0;
    localparam int          STOP_N    = (STOP_BITS == 2) ? 2 : 1;
    localparam int          NBITS     = 1 + 8 + PAR_EN + STOP_N;
    localparam logic [3:0]  LAST_BIT  = 4'(NBITS - 1);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Parity over the byte: even = XOR of all bits, odd = its inverse.
    function automatic logic parity_bit(input logic [7:0] d);
        logic p;
        p = ^d;
        if (PARITY == 2) begin
            p = ~p;
        end else begin
            p = p;
        end
        return p;
    endfunction

    // Bits that follow the start bit, in transmit order from bit 0. Slots
    // beyond the data are stop bits (1); slot 8 carries parity when enabled.
    // Shifting fills with ones, so the stop bits need no special handling.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f = {3'b111, d};
        if (PAR_EN == 1) begin
            f[8] = parity_bit(d);
        end else begin
            f[8] = 1'b1;
        end
        return f;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [10:0] shreg_q, shreg_d;
    logic        serial_out_q, serial_out_d;
    logic        empty_q, empty_d;

    logic        baud_wrap;
    logic        last_bit;

    assign baud_wrap = (baud_cnt_q == BAUD_LAST);
    assign last_bit  = (bit_idx_q == LAST_BIT);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (baud_wrap && last_bit) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values; outputs are registered so they are
    // glitch-free and empty drops in the cycle right after the accepting edge.
    always_comb begin
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        serial_out_d = serial_out_q;
        empty_d      = empty_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shreg_d      = frame_bits(data_in);
                    serial_out_d = 1'b0;
                    empty_d      = 1'b0;
                    baud_cnt_d   = 16'd0;
                    bit_idx_d    = 4'd0;
                end else begin
                    serial_out_d = 1'b1;
                    empty_d      = 1'b1;
                end
            end
            ST_SEND: begin
                if (baud_wrap) begin
                    baud_cnt_d = 16'd0;
                    if (last_bit) begin
                        // Last stop bit has had its full time: back to idle.
                        serial_out_d = 1'b1;
                        empty_d      = 1'b1;
                        bit_idx_d    = 4'd0;
                    end else begin
                        serial_out_d = shreg_q[0];
                        shreg_d      = {1'b1, shreg_q[10:1]};
                        bit_idx_d    = bit_idx_q + 4'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                serial_out_d = 1'b1;
                empty_d      = 1'b1;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt_q   <= 16'd0;
            bit_idx_q    <= 4'd0;
            shreg_q      <= 11'h7FF;
            serial_out_q <= 1'b1;
            empty_q      <= 1'b1;
        end else begin
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            serial_out_q <= serial_out_d;
            empty_q      <= empty_d;
        end
    end

    assign serial_out = serial_out_q;
    assign empty      = empty_q;

endmodule
